// File: rtl/video_tpg_multi.sv
// AXI4-Stream video test-pattern generator: solid / scrolling ramp / colour bars / checkerboard.
// Latency: first beat one clock after en is sampled high in IDLE; one beat per clock thereafter.
// Backpressure: tready low holds the registered beat; the frame simply stretches, never truncates.
module video_tpg_multi #(
   parameter int DATAW  = 32,
   parameter int BPC    = 8,
   parameter int SCRW   = 1280,
   parameter int SCRH   = 720,
   parameter int CHKLOG = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [1:0]           mode,
   input  logic [3*BPC-1:0]     solid_color,
   output logic [DATAW-1:0]     m_axis_tdata,
   output logic                 m_axis_tvalid,
   input  logic                 m_axis_tready,
   output logic                 m_axis_tuser,
   output logic                 m_axis_tlast,
   output logic [DATAW/8-1:0]   m_axis_tstrb,
   output logic [DATAW/8-1:0]   m_axis_tkeep,
   output logic                 m_axis_tid,
   output logic                 m_axis_tdest,
   output logic [15:0]          frame_cnt,
   output logic                 frame_done,
   output logic                 busy
);

   // Counters are widened so the checkerboard bit always exists, even on tiny test rasters.
   localparam int XW = ($clog2(SCRW) > CHKLOG) ? $clog2(SCRW) : CHKLOG + 1;
   localparam int YW = ($clog2(SCRH) > CHKLOG) ? $clog2(SCRH) : CHKLOG + 1;
   localparam logic [XW-1:0] XMAX = XW'(SCRW - 1);
   localparam logic [YW-1:0] YMAX = YW'(SCRH - 1);
   localparam logic [XW-1:0] BMAX = XW'(SCRW / 8 - 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t             state, state_n;
   logic [XW-1:0]      x, x_n;
   logic [YW-1:0]      y, y_n;
   logic [2:0]         bar, bar_n;
   logic [XW-1:0]      bpos, bpos_n;
   logic [1:0]         mode_q, mode_s;
   logic [3*BPC-1:0]   color_q, color_s;
   logic [BPC-1:0]     f_q, f_s;
   logic [BPC-1:0]     ramp;
   logic [3*BPC-1:0]   pix;
   logic               hs, last_beat, load, step, stop;

   assign m_axis_tstrb = '1;
   assign m_axis_tkeep = '1;
   assign m_axis_tid   = 1'b0;
   assign m_axis_tdest = 1'b0;
   assign busy         = (state == ACTIVE);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next state: start a frame from IDLE, chain frames at the last beat while en stays high
   always_comb begin
      state_n   = state;
      load      = 1'b0;
      step      = 1'b0;
      stop      = 1'b0;
      hs        = m_axis_tvalid & m_axis_tready;
      last_beat = hs && (x == XMAX) && (y == YMAX);
      case (state)
         IDLE: begin
            if (en) begin
               state_n = ACTIVE;
               load    = 1'b1;
            end
         end
         ACTIVE: begin
            if (last_beat) begin
               if (en) begin
                  load = 1'b1;
               end else begin
                  state_n = IDLE;
                  stop    = 1'b1;
               end
            end else if (hs) begin
               step = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Coordinates of the next beat; bar index advances on bar boundaries and saturates at 7
   always_comb begin
      x_n    = x;
      y_n    = y;
      bar_n  = bar;
      bpos_n = bpos;
      if (load) begin
         x_n    = '0;
         y_n    = '0;
         bar_n  = '0;
         bpos_n = '0;
      end else if (step) begin
         if (x == XMAX) begin
            x_n    = '0;
            y_n    = y + YW'(1);
            bar_n  = '0;
            bpos_n = '0;
         end else begin
            x_n = x + XW'(1);
            if (bar != 3'd7) begin
               if (bpos == BMAX) begin
                  bar_n  = bar + 3'd1;
                  bpos_n = '0;
               end else begin
                  bpos_n = bpos + XW'(1);
               end
            end
         end
      end
   end

   // Pattern parameters: a new frame takes live inputs, otherwise the values latched at SOF.
   // When chaining frames, the frame counter increments on the same edge, so use its next value.
   always_comb begin
      mode_s  = load ? mode : mode_q;
      color_s = load ? solid_color : color_q;
      if (load) f_s = last_beat ? BPC'(frame_cnt + 16'd1) : BPC'(frame_cnt);
      else      f_s = f_q;
   end

   // Pixel value of the next beat; component order is {R,B,G}
   always_comb begin
      pix  = '0;
      ramp = BPC'(x_n) + f_s;
      case (mode_s)
         2'd0: pix = color_s;
         2'd1: pix = {ramp, ramp, ramp};
         2'd2: pix = {{BPC{~bar_n[1]}}, {BPC{~bar_n[0]}}, {BPC{~bar_n[2]}}};
         2'd3: pix = (x_n[CHKLOG] ^ y_n[CHKLOG]) ? '1 : '0;
         default: pix = '0;
      endcase
   end

   // Registered stream outputs, position counters, SOF latches and frame statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x             <= '0;
         y             <= '0;
         bar           <= '0;
         bpos          <= '0;
         mode_q        <= '0;
         color_q       <= '0;
         f_q           <= '0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_cnt     <= '0;
         frame_done    <= 1'b0;
      end else begin
         frame_done <= last_beat;
         if (last_beat) frame_cnt <= frame_cnt + 16'd1;
         if (load) begin
            mode_q  <= mode;
            color_q <= solid_color;
            f_q     <= f_s;
         end
         if (load | step) begin
            x             <= x_n;
            y             <= y_n;
            bar           <= bar_n;
            bpos          <= bpos_n;
            m_axis_tdata  <= DATAW'(pix);
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= load;
            m_axis_tlast  <= (x_n == XMAX);
         end else if (stop) begin
            x             <= '0;
            y             <= '0;
            bar           <= '0;
            bpos          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
         end
      end
   end

endmodule
